// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA fill engine.
// Register map, field positions and coordinate typedefs.
package vga_pkg;

    localparam int XW_DEF = 8;
    localparam int YW_DEF = 7;

    typedef logic [XW_DEF-1:0] x_t;
    typedef logic [YW_DEF-1:0] y_t;
    typedef logic [7:0]        colour_t;

    localparam logic [3:0] OFF_PLOT   = 4'd0;
    localparam logic [3:0] OFF_RECT_A = 4'd1;
    localparam logic [3:0] OFF_RECT_B = 4'd2;
    localparam logic [3:0] OFF_CTRL   = 4'd3;
    localparam logic [3:0] OFF_STATUS = 4'd4;

    localparam int F_Y_LSB   = 24;
    localparam int F_X_LSB   = 16;
    localparam int F_COL_LSB = 0;
    localparam int F_IRQ_EN  = 8;
    localparam int F_BUSY    = 0;
    localparam int F_DONE    = 1;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

endpackage

// File: rtl/vga_rect_walker.sv
// Clips a rectangle to the screen and walks it in raster order,
// one pixel per clock while active.
module vga_rect_walker
    import vga_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          active,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [7:0]    colour,
    output logic          empty,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [7:0]    plot_colour,
    output logic          plot,
    output logic          last
);

    localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);

    logic [XW-1:0] x1c, x1c_q, x0_q;
    logic [YW-1:0] y1c, y1c_q;

    assign x1c   = (x1 > XMAX) ? XMAX : x1;
    assign y1c   = (y1 > YMAX) ? YMAX : y1;
    assign empty = (x0 > x1c) || (y0 > y1c);

    assign plot = active;
    assign last = active && (x == x1c_q) && (y == y1c_q);

    // Row end compares against the clipped corner, so counters never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            x0_q        <= '0;
            x1c_q       <= '0;
            y1c_q       <= '0;
            plot_colour <= '0;
        end else if (start && !empty) begin
            x           <= x0;
            y           <= y0;
            x0_q        <= x0;
            x1c_q       <= x1c;
            y1c_q       <= y1c;
            plot_colour <= colour;
        end else if (active && !last) begin
            if (x == x1c_q) begin
                x <= x0_q;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fill_engine.sv
// Avalon-MM slave owning the VGA plot port: single-pixel writes
// plus a hardware rectangle-fill sequencer.
module vga_fill_engine
    import vga_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    address,
    input  logic          read,
    output logic [31:0]   readdata,
    input  logic          write,
    input  logic [31:0]   writedata,
    output logic          waitrequest,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [7:0]    vga_colour,
    output logic          vga_plot,
    output logic          irq
);

    localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);

    fill_state_t state_q, state_d;

    logic          busy, wr_ok, start, done_clr;
    logic          done_q, done_d, irq_en_q, empty_pend_q;
    logic [XW-1:0] rx0_q, rx1_q, px_q, wx, fx;
    logic [YW-1:0] ry0_q, ry1_q, py_q, wy, fy;
    logic [7:0]    pc_q, fc;
    logic          pp_q, fplot, flast, fempty;
    logic          unused;

    assign wx = writedata[F_X_LSB +: XW];
    assign wy = writedata[F_Y_LSB +: YW];
    assign unused = ^{writedata[31], writedata[15:9]};

    assign busy        = (state_q == FILL);
    assign waitrequest = write && busy && (address <= OFF_CTRL);
    assign wr_ok       = write && !waitrequest;
    assign start       = wr_ok && (address == OFF_CTRL);
    assign done_clr    = wr_ok && (address == OFF_STATUS)
                         && writedata[F_DONE];

    assign readdata = (read && address == OFF_STATUS)
                      ? {30'd0, done_q, busy} : 32'd0;
    assign irq = done_q && irq_en_q;

    vga_rect_walker #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .XW(XW),
        .YW(YW)
    ) u_walker (
        .clk(clk),
        .reset(reset),
        .start(start),
        .active(busy),
        .x0(rx0_q),
        .y0(ry0_q),
        .x1(rx1_q),
        .y1(ry1_q),
        .colour(writedata[F_COL_LSB +: 8]),
        .empty(fempty),
        .x(fx),
        .y(fy),
        .plot_colour(fc),
        .plot(fplot),
        .last(flast)
    );

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: if (start && !fempty) state_d = FILL;
            FILL: if (flast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done_clr || start) done_d = 1'b0;
        // Completion beats a same-edge clear.
        if (flast || empty_pend_q) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            empty_pend_q <= 1'b0;
            rx0_q        <= '0;
            ry0_q        <= '0;
            rx1_q        <= '0;
            ry1_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            pc_q         <= '0;
            pp_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            empty_pend_q <= start && fempty;
            pp_q         <= 1'b0;
            if (start) irq_en_q <= writedata[F_IRQ_EN];
            if (wr_ok && address == OFF_RECT_A) begin
                rx0_q <= wx;
                ry0_q <= wy;
            end
            if (wr_ok && address == OFF_RECT_B) begin
                rx1_q <= wx;
                ry1_q <= wy;
            end
            if (wr_ok && address == OFF_PLOT) begin
                px_q <= wx;
                py_q <= wy;
                pc_q <= writedata[F_COL_LSB +: 8];
                pp_q <= (wx <= XMAX) && (wy <= YMAX);
            end
        end
    end

    // Fill owns the port while busy; a PLOT cannot overlap it.
    always_comb begin
        vga_x      = px_q;
        vga_y      = py_q;
        vga_colour = pc_q;
        vga_plot   = pp_q;
        if (fplot) begin
            vga_x      = fx;
            vga_y      = fy;
            vga_colour = fc;
            vga_plot   = 1'b1;
        end
    end

endmodule
